// File: rtl/inv_sub_bytes_engine.sv
// inv_sub_bytes_engine: multi-cycle AES InvSubBytes over a 128-bit state,
// BYTES_PER_CYCLE bytes substituted per BUSY cycle. Rev 1.0
`default_nettype none

module inv_sub_bytes_engine #(
  parameter int BYTES_PER_CYCLE = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_data,
  output logic         busy
);

  localparam int NCHUNK = 16 / BYTES_PER_CYCLE;
  localparam int CW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state, state_next;
  logic [CW-1:0]   chunk;
  logic [127:0]    work;
  logic [127:0]    work_next;
  logic            last_chunk;
  logic [7:0]      sbox_in  [BYTES_PER_CYCLE];
  logic [7:0]      sbox_out [BYTES_PER_CYCLE];

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p  = 8'h00;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // x^254 is the field inverse and maps 0 to 0 without a special case.
  function automatic logic [7:0] gf_inv(input logic [7:0] x);
    logic [7:0] r;
    logic [7:0] s;
    r = 8'h01;
    s = x;
    for (int i = 1; i < 8; i++) begin
      s = gf_mul(s, s);
      r = gf_mul(r, s);
    end
    return r;
  endfunction

  function automatic logic [7:0] inv_sbox(input logic [7:0] x);
    logic [7:0] y;
    for (int i = 0; i < 8; i++) begin
      y[i] = x[(i + 2) % 8] ^ x[(i + 5) % 8] ^ x[(i + 7) % 8];
    end
    y = y ^ 8'h05;
    return gf_inv(y);
  endfunction

  for (genvar j = 0; j < BYTES_PER_CYCLE; j++) begin : g_sbox
    assign sbox_in[j]  = work[127 - 8 * (int'(chunk) * BYTES_PER_CYCLE + j) -: 8];
    assign sbox_out[j] = inv_sbox(sbox_in[j]);
  end

  always_comb begin
    work_next = work;
    for (int j = 0; j < BYTES_PER_CYCLE; j++) begin
      work_next[127 - 8 * (int'(chunk) * BYTES_PER_CYCLE + j) -: 8] = sbox_out[j];
    end
  end

  assign last_chunk = (chunk == CW'(NCHUNK - 1));

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (in_valid)   state_next = BUSY;
      BUSY:    if (last_chunk) state_next = DONE;
      DONE:    if (out_ready)  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      chunk <= '0;
      work  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            work  <= in_data;
            chunk <= '0;
          end
        end
        BUSY: begin
          work <= work_next;
          // Hold at the last chunk so the counter never wraps into a spare pass.
          if (!last_chunk) chunk <= chunk + 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign out_data  = (state == DONE) ? work : 128'h0;
  assign busy      = (state != IDLE);

endmodule

`default_nettype wire

// File: tb/tb_inv_sub_bytes_engine.sv
// tb_inv_sub_bytes_engine: checks five engine instances (B = 1..16) against a
// table model derived from the forward S-box. Rev 1.0
`default_nettype none

module tb_inv_sub_bytes_engine;

  localparam int N = 5;
  localparam logic [127:0] KAT_IN  = 128'h637c777bf26b6fc53001672bfed7ab76;
  localparam logic [127:0] KAT_OUT = 128'h000102030405060708090a0b0c0d0e0f;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid  [N];
  logic         in_ready  [N];
  logic [127:0] in_data   [N];
  logic         out_valid [N];
  logic         out_ready [N];
  logic [127:0] out_data  [N];
  logic         busy      [N];

  int checks   = 0;
  int failures = 0;

  logic [7:0] sbox_t [256];
  logic [7:0] inv_t  [256];

  typedef struct {
    logic [127:0] din;
    logic [127:0] exp;
  } vec_t;
  vec_t vecs [4];

  always #5 clk = ~clk;

  for (genvar g = 0; g < N; g++) begin : g_dut
    inv_sub_bytes_engine #(.BYTES_PER_CYCLE(1 << g)) u_dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid[g]),
      .in_ready  (in_ready[g]),
      .in_data   (in_data[g]),
      .out_valid (out_valid[g]),
      .out_ready (out_ready[g]),
      .out_data  (out_data[g]),
      .busy      (busy[g])
    );
  end

  function automatic logic [7:0] ref_mul(input logic [7:0] a, input logic [7:0] b);
    int p = 0;
    int aa = int'(a);
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = aa << 1;
      if (aa > 255) aa = aa ^ 'h11b;
    end
    return 8'(p);
  endfunction

  function automatic logic [7:0] rotl(input logic [7:0] v, input int k);
    return 8'((v << k) | (v >> (8 - k)));
  endfunction

  function automatic logic [127:0] model(input logic [127:0] din);
    logic [127:0] r;
    for (int i = 0; i < 16; i++) r[127 - 8 * i -: 8] = inv_t[din[127 - 8 * i -: 8]];
    return r;
  endfunction

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic run_block(input int n, input logic [127:0] din, input logic [127:0] exp,
                           input int stall, input bit noisy, input string name);
    int lat;
    int guard;
    bit held_bad;
    guard = 0;
    while (!in_ready[n] && guard < 50) begin
      @(posedge clk); #1;
      guard++;
    end
    check({name, " ready"}, 128'(in_ready[n]), 128'd1);
    in_valid[n]  = 1'b1;
    in_data[n]   = din;
    out_ready[n] = (stall == 0);
    @(posedge clk); #1;
    check({name, " busy_after_accept"}, {126'd0, busy[n], in_ready[n]}, 128'd2);
    in_valid[n] = noisy;
    in_data[n]  = {$urandom, $urandom, $urandom, $urandom};
    lat = 0;
    do begin
      @(posedge clk); #1;
      lat++;
      if (noisy) in_data[n] = {$urandom, $urandom, $urandom, $urandom};
    end while (!out_valid[n] && lat < 40);
    in_valid[n] = 1'b0;
    check({name, " latency"}, 128'(lat), 128'(16 >> n));
    check({name, " data"}, out_data[n], exp);
    if (stall > 0) begin
      held_bad = 1'b0;
      repeat (stall) begin
        @(posedge clk); #1;
        if (!out_valid[n] || out_data[n] !== exp || in_ready[n]) held_bad = 1'b1;
      end
      check({name, " held_under_backpressure"}, 128'(held_bad), 128'd0);
      out_ready[n] = 1'b1;
    end
    @(posedge clk); #1;
    check({name, " idle_after_handshake"},
          {busy[n], out_valid[n], in_ready[n], out_data[n][124:0]}, {3'b001, 125'd0});
  endtask

  initial begin
    bit bad;
    logic [7:0] inv;
    logic [7:0] s;
    logic [127:0] blk;
    logic [127:0] exp;

    for (int a = 0; a < 256; a++) begin
      inv = 8'h00;
      for (int b = 1; b < 256; b++) if (a != 0 && ref_mul(8'(a), 8'(b)) == 8'h01) inv = 8'(b);
      s = inv ^ rotl(inv, 1) ^ rotl(inv, 2) ^ rotl(inv, 3) ^ rotl(inv, 4) ^ 8'h63;
      sbox_t[a] = s;
      inv_t[s]  = 8'(a);
    end

    vecs[0] = '{KAT_IN, KAT_OUT};
    vecs[1] = '{128'h006316527c0000000000000000000000, 128'h5200ff48015252525252525252525252};
    vecs[2] = '{128'h0, {16{8'h52}}};
    vecs[3] = '{{16{8'hff}}, {16{8'h7d}}};

    for (int n = 0; n < N; n++) begin
      in_valid[n]  = 1'b0;
      in_data[n]   = '0;
      out_ready[n] = 1'b1;
    end
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    for (int n = 0; n < N; n++)
      check($sformatf("reset_state[%0d]", n),
            {busy[n], out_valid[n], in_ready[n], out_data[n][124:0]}, {3'b001, 125'd0});

    for (int n = 0; n < N; n++)
      for (int v = 0; v < 4; v++)
        run_block(n, vecs[v].din, vecs[v].exp, 0, 1'b0, $sformatf("vec%0d_b%0d", v, 1 << n));

    for (int n = 0; n < N; n++)
      for (int k = 0; k < 16; k++) begin
        for (int i = 0; i < 16; i++) begin
          blk[127 - 8 * i -: 8] = sbox_t[16 * k + i];
          exp[127 - 8 * i -: 8] = 8'(16 * k + i);
        end
        run_block(n, blk, exp, 0, 1'b0, $sformatf("sweep%0d_b%0d", k, 1 << n));
      end

    run_block(2, KAT_IN, KAT_OUT, 10, 1'b0, "backpressure");
    run_block(2, vecs[1].din, vecs[1].exp, 0, 1'b1, "ignored_input");
    run_block(0, KAT_IN, KAT_OUT, 3, 1'b1, "ignored_input_b1");

    in_valid[2] = 1'b1;
    in_data[2]  = KAT_IN;
    @(posedge clk); #1;
    in_valid[2] = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    bad = 1'b0;
    repeat (8) begin
      if (out_valid[2] || out_data[2] !== 128'h0 || busy[2]) bad = 1'b1;
      @(posedge clk); #1;
    end
    check("reset_abort_no_output", 128'(bad), 128'd0);
    run_block(2, KAT_IN, KAT_OUT, 0, 1'b0, "after_reset_kat");

    for (int t = 0; t < 40; t++) begin
      int n;
      n = int'($urandom_range(0, N - 1));
      blk = {$urandom, $urandom, $urandom, $urandom};
      run_block(n, blk, model(blk), int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                $sformatf("rand%0d_b%0d", t, 1 << n));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/inv_sub_bytes_engine.md
INV_SUB_BYTES_ENGINE -- requirements
Module: inv_sub_bytes_engine

Interface
REQ-001 Parameter: BYTES_PER_CYCLE, default 4, number of state bytes substituted per BUSY cycle; legal values 1, 2, 4, 8, 16.
REQ-002 Port: clk  input  1  single clock; all state changes on rising edge.
REQ-003 Port: rst  input  1  reset; synchronous and active-high.
REQ-004 Port: in_valid  input  1  in_data holds a 128-bit ciphertext state to be inverse-substituted.
REQ-005 Port: in_ready  output  1  engine can accept a block.
REQ-006 Port: in_data  input  128  input state; byte 0 = bits [127:120], byte 15 = bits [7:0].
REQ-007 Port: out_valid  output  1  out_data holds a completed result.
REQ-008 Port: out_ready  input  1  consumer accepts out_data.
REQ-009 Port: out_data  output  128  inverse-substituted state; same byte order as in_data.
REQ-010 Port: busy  output  1  high whenever state is not IDLE.

Function
REQ-011 InvSBox(x) SHALL equal the GF(2^8) multiplicative inverse (polynomial 0x11B, inverse of 0x00 defined as 0x00) of y, where y_i = x_(i+2 mod 8) ^ x_(i+5 mod 8) ^ x_(i+7 mod 8) ^ c_i with c = 0x05; equivalently, InvSBox(SBox(v)) = v for all 256 v.
REQ-012 Byte substitution SHALL be realised by BYTES_PER_CYCLE parallel InvSBox instances; any table or arithmetic realisation is permitted.
REQ-013 FSM states: IDLE, BUSY, DONE; reset state IDLE.
REQ-014 IDLE: in_ready=1; on in_valid=1, latch in_data into the working register, clear the chunk counter, go to BUSY.
REQ-015 BUSY: each cycle replace bytes [k*B .. k*B+B-1] (B = BYTES_PER_CYCLE, k = chunk counter) of the working register with their InvSBox values, then increment k.
REQ-016 When the chunk being processed is the last (k = 16/B - 1), go to DONE on that edge; the counter SHALL NOT wrap into a further chunk.
REQ-017 Latency: out_valid SHALL rise exactly 16/B cycles after the acceptance edge (4 cycles at default).
REQ-018 DONE: out_valid=1, out_data = working register, both held stable until out_ready=1; on out_valid & out_ready go to IDLE.
REQ-019 in_ready SHALL be 0 in BUSY and DONE; in_valid during those states is ignored, and in_data changes there SHALL NOT affect the result.
REQ-020 One block in flight at a time; a new block is accepted no earlier than the cycle after the DONE handshake.
REQ-021 out_data SHALL be 0 whenever out_valid=0.
REQ-022 busy = (state != IDLE).

Reset
REQ-023 rst=1 at a clock edge SHALL force IDLE, counter 0, working register 0; reset values: in_ready=1 (after release), out_valid=0, out_data=0, busy=0.
REQ-024 Reset asserted in BUSY or DONE SHALL abort the block with no output handshake; the next block after release SHALL be processed correctly.
REQ-025 rst has priority over all other inputs in the same cycle.

Verification
REQ-026 Known-answer: in_data=0x637c777bf26b6fc53001672bfed7ab76, out_ready=1 -> out_data=0x000102030405060708090a0b0c0d0e0f, out_valid high 4 cycles after acceptance (B=4).
REQ-027 Boundary bytes: in_data bytes {0x00, 0x63, 0x16, 0x52, 0x7c, ...} -> corresponding outputs {0x52, 0x00, 0xff, 0x48, 0x01}; exhaustive sweep of all 256 byte values over 16 blocks checks InvSBox(SBox(v)) = v.
REQ-028 Backpressure: out_ready=0 for 10 cycles after out_valid rises -> out_valid and out_data stable, in_ready=0 throughout; out_ready=1 -> return to IDLE next cycle.
REQ-029 Ignored input: in_valid=1 with changing in_data during BUSY -> result equals transform of the originally accepted block only.
REQ-030 Reset mid-operation: rst pulsed in 2nd BUSY cycle -> out_valid never asserts for that block, out_data=0; the following block yields the correct known-answer result.
REQ-031 Parameter sweep: repeat REQ-026 for B = 1, 2, 8, 16 -> latency 16, 8, 2, 1 cycles respectively, identical out_data.
